// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the two requesters (ALU, LSU), the arbiter and the
// register file write port.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_data;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_data;

    logic                  rf_wen;
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0] rf_wdata;

    // Requester / register-file side.
    modport master (
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  rf_wen, rf_waddr, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output rf_wen, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU (req0)
// and LSU (req1) write-back, with a registered write port and a per-register
// busy scoreboard used by issue logic for RAW hazard detection.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    regfile_wb_arbiter_if.slave   wb,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  hazard_rs1,
    output logic                  hazard_rs2,
    input  logic                  sb_clear
);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    // last_grant encoding: 0 = req0 was granted last, 1 = req1 was granted last.
    logic                  last_grant_q, last_grant_d;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic                  grant0, grant1;
    logic                  handshake;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    // Arbitration: a lone requester wins; on conflict the one not granted last wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (wb.req0_valid && wb.req1_valid) begin
            grant0 = last_grant_q;
            grant1 = !last_grant_q;
        end else begin
            grant0 = wb.req0_valid;
            grant1 = wb.req1_valid;
        end
    end

    assign wb.req0_ready = grant0;
    assign wb.req1_ready = grant1;
    assign handshake     = grant0 || grant1;
    assign sel_addr      = grant1 ? wb.req1_addr : wb.req0_addr;
    assign sel_data      = grant1 ? wb.req1_data : wb.req0_data;

    // Next state of the pointer and the write port; x0 requests complete but never write.
    always_comb begin
        last_grant_d = last_grant_q;
        rf_wen_d     = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        if (handshake) begin
            last_grant_d = grant1;
            if (sel_addr != '0) begin
                rf_wen_d   = 1'b1;
                rf_waddr_d = sel_addr;
                rf_wdata_d = sel_data;
            end
        end
    end

    // Scoreboard update: clear on commit, then set on issue (set wins), flush overrides all.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q && (rf_waddr_q != '0)) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        if (sb_clear) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers; reset drops any pending write and clears the scoreboard.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
        if (!rstn) begin
            last_grant_q <= 1'b1;
            rf_wen_q     <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            // NOTE: the busy array is reset because issue logic relies on it being all-clear
            // after reset; a plain data array would not need this.
            busy_q       <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_wen_q     <= rf_wen_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign wb.rf_wen   = rf_wen_q;
    assign wb.rf_waddr = rf_waddr_q;
    assign wb.rf_wdata = rf_wdata_q;

    // Hazard lookup is straight from current busy state; busy_q[0] is always 0.
    assign hazard_rs1 = busy_q[rs1];
    assign hazard_rs2 = busy_q[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          hazard_rs1;
    logic          hazard_rs2;
    logic          sb_clear;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    regfile_wb_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .wb          (wb),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard_rs1  (hazard_rs1),
        .hazard_rs2  (hazard_rs2),
        .sb_clear    (sb_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req0(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.req0_valid = v;
        wb.req0_addr  = a;
        wb.req0_data  = d;
    endtask

    task automatic drive_req1(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb.req1_valid = v;
        wb.req1_addr  = a;
        wb.req1_data  = d;
    endtask

    initial begin
        rstn        = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = 5'd5;
        rs2         = 5'd7;
        sb_clear    = 1'b0;
        drive_req0(1'b0, '0, '0);
        drive_req1(1'b0, '0, '0);

        // Reset state
        #12;
        check("rst_wen",   32'(wb.rf_wen),   32'd0);
        check("rst_waddr", 32'(wb.rf_waddr), 32'd0);
        check("rst_wdata", wb.rf_wdata,      32'd0);
        check("rst_haz1",  32'(hazard_rs1),  32'd0);
        check("rst_haz2",  32'(hazard_rs2),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc();

        // Conflict after reset: grants 0,1,0,1 with fresh data after each grant
        drive_req0(1'b1, 5'd1, 32'h11);
        drive_req1(1'b1, 5'd2, 32'h22);
        #1;
        check("cf1_rdy0", 32'(wb.req0_ready), 32'd1);
        check("cf1_rdy1", 32'(wb.req1_ready), 32'd0);
        cyc();
        wb.req0_data = 32'h12;
        #1;
        check("cf1_wen",   32'(wb.rf_wen),     32'd1);
        check("cf1_waddr", 32'(wb.rf_waddr),   32'd1);
        check("cf1_wdata", wb.rf_wdata,        32'h11);
        check("cf2_rdy0",  32'(wb.req0_ready), 32'd0);
        check("cf2_rdy1",  32'(wb.req1_ready), 32'd1);
        cyc();
        wb.req1_data = 32'h23;
        #1;
        check("cf2_wen",   32'(wb.rf_wen),     32'd1);
        check("cf2_waddr", 32'(wb.rf_waddr),   32'd2);
        check("cf2_wdata", wb.rf_wdata,        32'h22);
        check("cf3_rdy0",  32'(wb.req0_ready), 32'd1);
        check("cf3_rdy1",  32'(wb.req1_ready), 32'd0);
        cyc();
        wb.req0_data = 32'h13;
        #1;
        check("cf3_wen",   32'(wb.rf_wen),     32'd1);
        check("cf3_waddr", 32'(wb.rf_waddr),   32'd1);
        check("cf3_wdata", wb.rf_wdata,        32'h12);
        check("cf4_rdy0",  32'(wb.req0_ready), 32'd0);
        check("cf4_rdy1",  32'(wb.req1_ready), 32'd1);
        cyc();
        drive_req0(1'b0, '0, '0);
        drive_req1(1'b0, '0, '0);
        #1;
        check("cf4_wen",   32'(wb.rf_wen),   32'd1);
        check("cf4_waddr", 32'(wb.rf_waddr), 32'd2);
        check("cf4_wdata", wb.rf_wdata,      32'h23);
        cyc();
        check("cf_idle_wen", 32'(wb.rf_wen), 32'd0);

        // Single request from req0
        drive_req0(1'b1, 5'd3, 32'hDEADBEEF);
        #1;
        check("single_rdy0", 32'(wb.req0_ready), 32'd1);
        check("single_rdy1", 32'(wb.req1_ready), 32'd0);
        cyc();
        drive_req0(1'b0, '0, '0);
        #1;
        check("single_wen",   32'(wb.rf_wen),   32'd1);
        check("single_waddr", 32'(wb.rf_waddr), 32'd3);
        check("single_wdata", wb.rf_wdata,      32'hDEADBEEF);
        cyc();
        check("single_wen_off", 32'(wb.rf_wen),   32'd0);
        check("single_hold_a",  32'(wb.rf_waddr), 32'd3);
        check("single_hold_d",  wb.rf_wdata,      32'hDEADBEEF);

        // x0 write from req1: handshaken, no write, pointer rotates to req1
        drive_req1(1'b1, 5'd0, 32'h55);
        #1;
        check("x0_rdy1", 32'(wb.req1_ready), 32'd1);
        check("x0_rdy0", 32'(wb.req0_ready), 32'd0);
        cyc();
        drive_req0(1'b1, 5'd4, 32'h44);
        drive_req1(1'b1, 5'd6, 32'h66);
        #1;
        check("x0_wen",       32'(wb.rf_wen),     32'd0);
        check("x0_next_rdy0", 32'(wb.req0_ready), 32'd1);
        check("x0_next_rdy1", 32'(wb.req1_ready), 32'd0);
        cyc();
        drive_req0(1'b0, '0, '0);
        #1;
        check("x0_next_waddr", 32'(wb.rf_waddr),   32'd4);
        check("x0_r1_rdy",     32'(wb.req1_ready), 32'd1);
        cyc();
        drive_req1(1'b0, '0, '0);
        #1;
        check("x0_r1_waddr", 32'(wb.rf_waddr), 32'd6);
        check("x0_r1_wdata", wb.rf_wdata,      32'h66);
        cyc();

        // Scoreboard timing on rd=7
        rs1 = 5'd7;
        rs2 = 5'd0;
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        #1;
        check("sb_pre_haz1", 32'(hazard_rs1), 32'd0);
        cyc();
        issue_valid = 1'b0;
        #1;
        check("sb_set_haz1", 32'(hazard_rs1), 32'd1);
        check("sb_rs0_haz2", 32'(hazard_rs2), 32'd0);
        drive_req0(1'b1, 5'd7, 32'h77);
        #1;
        check("sb_wr_rdy0", 32'(wb.req0_ready), 32'd1);
        cyc();
        drive_req0(1'b0, '0, '0);
        #1;
        check("sb_wr_wen",   32'(wb.rf_wen), 32'd1);
        check("sb_hold_haz", 32'(hazard_rs1), 32'd1);
        cyc();
        check("sb_clr_haz", 32'(hazard_rs1), 32'd0);

        // Collision: commit to 9 while re-issuing 9, set wins
        rs1 = 5'd9;
        rs2 = 5'd12;
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        cyc();
        issue_valid = 1'b0;
        drive_req0(1'b1, 5'd9, 32'h99);
        cyc();
        drive_req0(1'b0, '0, '0);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        #1;
        check("col_wen",   32'(wb.rf_wen),   32'd1);
        check("col_waddr", 32'(wb.rf_waddr), 32'd9);
        cyc();
        issue_valid = 1'b0;
        #1;
        check("col_busy9", 32'(hazard_rs1), 32'd1);

        // Same collision with sb_clear, plus an unrelated busy register 12
        drive_req0(1'b1, 5'd9, 32'h9A);
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        cyc();
        drive_req0(1'b0, '0, '0);
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        sb_clear    = 1'b1;
        #1;
        check("flush_pre_haz2", 32'(hazard_rs2), 32'd1);
        check("flush_wen",      32'(wb.rf_wen),  32'd1);
        cyc();
        issue_valid = 1'b0;
        sb_clear    = 1'b0;
        #1;
        check("flush_haz1", 32'(hazard_rs1), 32'd0);
        check("flush_haz2", 32'(hazard_rs2), 32'd0);
        cyc();

        // Reset mid-operation with rf_wen=1 and busy[5]=1
        rs1 = 5'd5;
        rs2 = 5'd5;
        issue_valid = 1'b1;
        issue_rd    = 5'd5;
        cyc();
        issue_valid = 1'b0;
        drive_req1(1'b1, 5'd5, 32'h55AA);
        cyc();
        drive_req1(1'b0, '0, '0);
        #1;
        check("mid_pre_wen",  32'(wb.rf_wen),  32'd1);
        check("mid_pre_haz1", 32'(hazard_rs1), 32'd1);
        rstn = 1'b0;
        #1;
        check("mid_rst_wen",   32'(wb.rf_wen),   32'd0);
        check("mid_rst_waddr", 32'(wb.rf_waddr), 32'd0);
        check("mid_rst_wdata", wb.rf_wdata,      32'd0);
        check("mid_rst_haz1",  32'(hazard_rs1),  32'd0);
        check("mid_rst_haz2",  32'(hazard_rs2),  32'd0);
        @(negedge clk);
        rstn = 1'b1;
        cyc();
        check("post_rst_wen", 32'(wb.rf_wen), 32'd0);
        // Last write was req1; reset must restore req0 priority
        drive_req0(1'b1, 5'd1, 32'h1);
        drive_req1(1'b1, 5'd2, 32'h2);
        #1;
        check("post_rst_rdy0", 32'(wb.req0_ready), 32'd1);
        check("post_rst_rdy1", 32'(wb.req1_ready), 32'd0);
        cyc();
        drive_req0(1'b0, '0, '0);
        drive_req1(1'b0, '0, '0);
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: req0 (ALU/EXU) and req1 (LSU load data).
- Uses valid/ready handshakes and round-robin arbitration, and drives a registered write port (wen/waddr/wdata) into the register file.
- Holds a per-register busy scoreboard. Issue logic uses it to detect RAW hazards against pending writes.
- Sits between EXU/LSU write-back and the register file.

Parameters:
- ADDR_WIDTH, 5, register index width; the block covers 2^ADDR_WIDTH registers.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU write-back request.
- req0_ready  out  1  req0 accepted this cycle.
- req0_addr  in  ADDR_WIDTH  destination register for req0.
- req0_data  in  DATA_WIDTH  write data for req0.
- req1_valid  in  1  LSU write-back request.
- req1_ready  out  1  req1 accepted this cycle.
- req1_addr  in  ADDR_WIDTH  destination register for req1.
- req1_data  in  DATA_WIDTH  write data for req1.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.
- issue_valid  in  1  an instruction with destination issue_rd is issuing.
- issue_rd  in  ADDR_WIDTH  destination register being issued.
- rs1  in  ADDR_WIDTH  source register 1 to query.
- rs2  in  ADDR_WIDTH  source register 2 to query.
- hazard_rs1  out  1  rs1 has a write pending.
- hazard_rs2  out  1  rs2 has a write pending.
- sb_clear  in  1  synchronous flush of all busy bits.

Behaviour:
- Reset (rstn low, asynchronous):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - All busy bits 0.
  - Round-robin pointer last_grant=1, so req0 has priority on the first conflict.
  - Release is synchronous to the next clk edge.
  - Reset mid-operation drops any accepted but unwritten request and clears every busy bit.
- Arbitration (combinational, every cycle):
  - Only one valid: it is granted.
  - Both valid: grant the one that is not last_grant.
  - Neither valid: no grant.
  - reqN_ready = grant to N. At most one ready per cycle; a ready is never asserted without the matching valid.
  - last_grant updates on each handshake and holds otherwise.
- Handshake:
  - Transfer occurs on a rising edge with reqN_valid && reqN_ready.
  - A requester holds valid, addr and data stable until ready. Changing them while stalled is undefined.
- Write port (1-cycle latency):
  - A handshake at edge N registers rf_waddr and rf_wdata, and sets rf_wen=1 during cycle N..N+1.
  - The register file commits the write at edge N+1.
  - Without a handshake, rf_wen=0 next cycle and rf_waddr/rf_wdata hold their last values.
  - Throughput is one write per cycle, so back-to-back grants give back-to-back rf_wen.
- x0 rule: a request with addr=0 is still handshaken (ready=1) and rotates the pointer, but rf_wen stays 0 for it.
- Scoreboard (busy[i], i = 1..2^ADDR_WIDTH-1; busy[0] is constant 0):
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd] at the edge.
  - Clear: rf_wen && rf_waddr!=0 clears busy[rf_waddr] at the edge, i.e. the same edge the register file commits the write.
  - Set and clear on the same index in the same cycle: set wins, because a new producer is in flight.
  - Set and clear on different indices in the same cycle: both apply.
  - sb_clear=1 clears all busy bits at the edge and overrides an issue set in the same cycle.
  - A pending rf_wen still commits to the register file after sb_clear.
  - hazard_rs1 = busy[rs1] and hazard_rs2 = busy[rs2], combinational from the current busy state. There is no bypass. rs=0 always reads 0.
  - Issuing to an already-busy register keeps it busy. There is no counting: the first matching write clears it.

Test Plan:
- Reset: assert rstn=0 mid-stream with rf_wen=1 and busy[5]=1 → rf_wen=0, rf_waddr=0, rf_wdata=0 and hazards 0 immediately, before any clk edge.
- Single request: req0 valid, addr=3, data=0xDEADBEEF → req0_ready=1 the same cycle; the next cycle has rf_wen=1, rf_waddr=3, rf_wdata=0xDEADBEEF; the following cycle has rf_wen=0.
- Conflict: hold both requests valid (req0 addr 1/0x11, req1 addr 2/0x22, new data after each grant) for 4 cycles after reset → grant order 0,1,0,1 and rf_wen=1 on 4 consecutive cycles.
- x0 write: req1 valid, addr=0, data=0x55 → req1_ready=1, rf_wen stays 0, and req0 wins the next conflict.
- Scoreboard timing: issue rd=7, then rs1=7 → hazard_rs1=1. A req0 write to 7 handshakes at edge N; hazard_rs1 stays 1 through cycle N..N+1 and drops after edge N+1.
- Collision: rf_wen to rd=9 while issue_valid with rd=9 in the same cycle → busy[9] stays 1. Repeat with sb_clear=1 asserted → busy[9]=0 and every hazard output 0.
